// File: rtl/sibling_merge_pkg.sv
// sibling_merge_pkg: shared defaults and types for the sibling stream merge.
package sibling_merge_pkg;

    localparam int N_SRC_DEF      = 5;
    localparam int DATA_W_DEF     = 16;
    localparam int FIFO_DEPTH_DEF = 4;

    // Width of a source index for a group of n siblings.
    function automatic int src_idx_w(input int n);
        return $clog2(n);
    endfunction

    localparam int SRC_W_DEF = $clog2(N_SRC_DEF);

    // FIFO entry layout for the default configuration: source tag above payload.
    typedef struct packed {
        logic [SRC_W_DEF-1:0]  src;
        logic [DATA_W_DEF-1:0] data;
    } merge_entry_t;

endpackage

// File: rtl/merge_sync_fifo.sv
// merge_sync_fifo: single-clock FIFO with registered storage and occupancy output.
module merge_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;
    logic [AW-1:0]    head_idx;

    // The extra pointer bit tells full from empty; the difference is the occupancy.
    assign level   = wr_ptr_q - rd_ptr_q;
    assign do_push = push && (level < (AW+1)'(DEPTH));
    assign do_pop  = pop && (level != '0);

    // When empty, present the most recently popped slot so the head holds its last value.
    assign head_idx  = (level == '0) ? (rd_ptr_q[AW-1:0] - AW'(1)) : rd_ptr_q[AW-1:0];
    assign head_data = mem_q[head_idx];

    // Next-state for storage and pointers from this cycle's push and pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    // Register storage and pointers; reset empties the FIFO and zeroes storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/sibling_stream_merge.sv
// sibling_stream_merge: round-robin merge of sibling valid/ready streams into one tagged stream.
module sibling_stream_merge
    import sibling_merge_pkg::*;
#(
    parameter int N_SRC      = N_SRC_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int CNT_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_SRC-1:0]            in_valid,
    output logic [N_SRC-1:0]            in_ready,
    input  logic [N_SRC*DATA_W-1:0]     in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_data,
    output logic [$clog2(N_SRC)-1:0]    out_src,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    input  logic                        clear_cnt,
    output logic [CNT_W-1:0]            beat_count
);

    localparam int SRC_W = src_idx_w(N_SRC);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [SRC_W-1:0]  src;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  beat_count_q, beat_count_d;
    logic [SRC_W-1:0]  grant;
    logic              any_valid;
    logic              space;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] sel_data;
    entry_t            push_entry;
    entry_t            head_entry;

    // First valid source at or after ptr, wrapping explicitly at N_SRC; ptr if none is valid.
    function automatic logic [SRC_W-1:0] pick_grant(input logic [N_SRC-1:0] valid,
                                                    input logic [SRC_W-1:0] ptr);
        logic [SRC_W-1:0] sel;
        logic [SRC_W:0]   cand;
        sel = ptr;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + (SRC_W+1)'(k);
            if (cand >= (SRC_W+1)'(N_SRC)) begin
                cand = cand - (SRC_W+1)'(N_SRC);
            end
            if (valid[cand[SRC_W-1:0]]) begin
                sel = cand[SRC_W-1:0];
            end
        end
        return sel;
    endfunction

    // Arbitration: space comes only from the registered level, so a same-cycle pop never frees a slot.
    always_comb begin
        grant     = pick_grant(in_valid, rr_ptr_q);
        any_valid = |in_valid;
        space     = fifo_level < LVL_W'(FIFO_DEPTH);
        push      = space && any_valid && !rst;
        in_ready  = '0;
        sel_data  = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (grant == SRC_W'(i)) begin
                in_ready[i] = push;
                sel_data    = in_data[i*DATA_W +: DATA_W];
            end
        end
        push_entry.src  = grant;
        push_entry.data = sel_data;
    end

    // Pointer moves past the granted source on a push; the counter saturates and clear wins.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (push) begin
            rr_ptr_d = (grant == SRC_W'(N_SRC - 1)) ? '0 : grant + SRC_W'(1);
        end
        beat_count_d = beat_count_q;
        if (clear_cnt) begin
            beat_count_d = '0;
        end else if (push && (beat_count_q != '1)) begin
            beat_count_d = beat_count_q + CNT_W'(1);
        end
    end

    // Arbiter pointer and beat counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q     <= '0;
            beat_count_q <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            beat_count_q <= beat_count_d;
        end
    end

    merge_sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head_entry),
        .level     (fifo_level)
    );

    assign out_valid  = (fifo_level != '0);
    assign pop        = out_valid && out_ready;
    assign out_data   = head_entry.data;
    assign out_src    = head_entry.src;
    assign beat_count = beat_count_q;

endmodule

// File: tb/tb_sibling_stream_merge.sv
// tb_sibling_stream_merge: directed stimulus with a queue-based reference model checked every cycle.
module tb_sibling_stream_merge;
    import sibling_merge_pkg::*;

    localparam int N_SRC      = 5;
    localparam int DATA_W     = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = 4;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic                    clk;
    logic                    rst;
    logic [N_SRC-1:0]        in_valid;
    logic [N_SRC-1:0]        in_ready;
    logic [N_SRC*DATA_W-1:0] in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_W-1:0]       out_data;
    logic [2:0]              out_src;
    logic [2:0]              fifo_level;
    logic                    clear_cnt;
    logic [CNT_W-1:0]        beat_count;

    int n_vectors;
    int n_miscompares;

    merge_entry_t     model_q [$];
    merge_entry_t     model_e;
    int               model_rr;
    int               model_cnt;
    int               model_grant;
    logic [N_SRC-1:0] exp_ready;

    sibling_stream_merge #(
        .N_SRC      (N_SRC),
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_src    (out_src),
        .fifo_level (fifo_level),
        .clear_cnt  (clear_cnt),
        .beat_count (beat_count)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [N_SRC-1:0] valid, input logic ready, input logic clr);
        in_valid  = valid;
        out_ready = ready;
        clear_cnt = clr;
    endtask

    task automatic setPayload(input int src, input logic [DATA_W-1:0] value);
        in_data[src*DATA_W +: DATA_W] = value;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        applyStimulus('0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Reference model: the FIFO is a queue, arbitration a modular search from the last grant + 1.
    // Outputs are checked on the falling edge, then the model advances to the state after the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            model_q.delete();
            model_rr  = 0;
            model_cnt = 0;
            checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
            checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
            checkOutput("rst_level", 32'(fifo_level), 32'd0);
            checkOutput("rst_beat_count", 32'(beat_count), 32'd0);
            checkOutput("rst_out_data", 32'(out_data), 32'd0);
            checkOutput("rst_out_src", 32'(out_src), 32'd0);
        end else begin
            model_grant = -1;
            if (model_q.size() < FIFO_DEPTH) begin
                for (int k = 0; k < N_SRC; k++) begin
                    if (model_grant < 0 && in_valid[(model_rr + k) % N_SRC]) begin
                        model_grant = (model_rr + k) % N_SRC;
                    end
                end
            end
            exp_ready = '0;
            if (model_grant >= 0) exp_ready[model_grant] = 1'b1;

            checkOutput("in_ready", 32'(in_ready), 32'(exp_ready));
            checkOutput("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
            checkOutput("fifo_level", 32'(fifo_level), 32'(model_q.size()));
            checkOutput("beat_count", 32'(beat_count), 32'(model_cnt));
            if (model_q.size() != 0) begin
                checkOutput("out_data", 32'(out_data), 32'(model_q[0].data));
                checkOutput("out_src", 32'(out_src), 32'(model_q[0].src));
            end

            if (model_q.size() != 0 && out_ready) begin
                void'(model_q.pop_front());
            end
            if (model_grant >= 0) begin
                model_e.src  = 3'(model_grant);
                model_e.data = in_data[model_grant*DATA_W +: DATA_W];
                model_q.push_back(model_e);
                model_rr = (model_grant + 1) % N_SRC;
                if (model_cnt < CNT_MAX) model_cnt++;
            end
            if (clear_cnt) model_cnt = 0;
        end
    end

    // Directed scenarios with hand-computed expectations.
    initial begin
        int exp_seq [7];
        n_vectors     = 0;
        n_miscompares = 0;
        rst       = 1'b1;
        in_valid  = '0;
        out_ready = 1'b0;
        clear_cnt = 1'b0;
        in_data   = '0;
        exp_seq   = '{0, 1, 2, 3, 4, 0, 1};

        // Single source, two beats: one cycle latency, back-to-back output.
        doReset();
        applyStimulus(5'b00100, 1'b1, 1'b0);
        setPayload(2, 16'h00A1);
        #1;
        checkOutput("t1_ready_first", 32'(in_ready), 32'h04);
        checkOutput("t1_no_comb_path", 32'(out_valid), 32'd0);
        stepCycle();
        setPayload(2, 16'h00A2);
        checkOutput("t1_beat1_data", 32'(out_data), 32'h00A1);
        checkOutput("t1_beat1_src", 32'(out_src), 32'd2);
        checkOutput("t1_beat1_valid", 32'(out_valid), 32'd1);
        stepCycle();
        applyStimulus('0, 1'b1, 1'b0);
        checkOutput("t1_beat2_data", 32'(out_data), 32'h00A2);
        checkOutput("t1_beat2_valid", 32'(out_valid), 32'd1);
        stepCycle();
        checkOutput("t1_drained", 32'(out_valid), 32'd0);
        checkOutput("t1_count", 32'(beat_count), 32'd2);

        // All sources valid, no backpressure: strict rotation, level steady at 1.
        doReset();
        applyStimulus('1, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            for (int s = 0; s < N_SRC; s++) setPayload(s, 16'((s << 8) | i));
            stepCycle();
            checkOutput("t2_src_seq", 32'(out_src), 32'(exp_seq[i]));
            checkOutput("t2_level", 32'(fifo_level), 32'd1);
        end

        // All valid with backpressure: fill with 0..3, stall, then drain in order and grant 4.
        doReset();
        applyStimulus('1, 1'b0, 1'b0);
        repeat (4) stepCycle();
        checkOutput("t3_full_level", 32'(fifo_level), 32'd4);
        checkOutput("t3_full_ready", 32'(in_ready), 32'd0);
        repeat (2) stepCycle();
        checkOutput("t3_hold_level", 32'(fifo_level), 32'd4);
        checkOutput("t3_head0", 32'(out_src), 32'd0);
        applyStimulus('1, 1'b1, 1'b0);
        stepCycle();
        checkOutput("t3_level_after_pop", 32'(fifo_level), 32'd3);
        checkOutput("t3_grant4", 32'(in_ready), 32'h10);
        checkOutput("t3_head1", 32'(out_src), 32'd1);
        stepCycle();
        checkOutput("t3_head2", 32'(out_src), 32'd2);
        stepCycle();
        checkOutput("t3_head3", 32'(out_src), 32'd3);
        stepCycle();
        checkOutput("t3_head4", 32'(out_src), 32'd4);

        // Push and pop in the same cycle at level 2.
        doReset();
        applyStimulus(5'b00010, 1'b0, 1'b0);
        setPayload(1, 16'h0B01);
        stepCycle();
        setPayload(1, 16'h0B02);
        stepCycle();
        checkOutput("t4_level2", 32'(fifo_level), 32'd2);
        setPayload(1, 16'h0B03);
        applyStimulus(5'b00010, 1'b1, 1'b0);
        checkOutput("t4_head_oldest", 32'(out_data), 32'h0B01);
        stepCycle();
        applyStimulus('0, 1'b1, 1'b0);
        checkOutput("t4_level_held", 32'(fifo_level), 32'd2);
        checkOutput("t4_next_head", 32'(out_data), 32'h0B02);
        stepCycle();
        checkOutput("t4_tail", 32'(out_data), 32'h0B03);
        checkOutput("t4_level1", 32'(fifo_level), 32'd1);

        // Counter saturation and clear priority over a simultaneous push.
        doReset();
        applyStimulus(5'b00001, 1'b1, 1'b0);
        repeat (15) stepCycle();
        checkOutput("t5_count15", 32'(beat_count), 32'd15);
        repeat (5) stepCycle();
        checkOutput("t5_saturated", 32'(beat_count), 32'd15);
        applyStimulus(5'b00001, 1'b1, 1'b1);
        stepCycle();
        applyStimulus(5'b00001, 1'b1, 1'b0);
        checkOutput("t5_cleared", 32'(beat_count), 32'd0);
        stepCycle();
        checkOutput("t5_after_clear1", 32'(beat_count), 32'd1);
        stepCycle();
        checkOutput("t5_after_clear2", 32'(beat_count), 32'd2);

        // Asynchronous reset mid-cycle with three beats buffered.
        doReset();
        applyStimulus(5'b01000, 1'b0, 1'b0);
        repeat (3) stepCycle();
        checkOutput("t6_level3", 32'(fifo_level), 32'd3);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("t6_async_valid", 32'(out_valid), 32'd0);
        checkOutput("t6_async_level", 32'(fifo_level), 32'd0);
        checkOutput("t6_async_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus('1, 1'b0, 1'b0);
        #1;
        checkOutput("t6_first_grant", 32'(in_ready), 32'h01);
        stepCycle();
        checkOutput("t6_first_src", 32'(out_src), 32'd0);
        checkOutput("t6_first_valid", 32'(out_valid), 32'd1);

        applyStimulus('0, 1'b0, 1'b0);
        stepCycle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/sibling_stream_merge.md
Name: sibling_stream_merge

Overview:
- Consumer stage for a group of N_SRC sibling leaf instances under one hierarchy node; default N_SRC=5 matches the five-child fan-out.
- Merges the siblings' valid/ready streams into one ordered output stream.
- Arbitration is round-robin into a small FIFO; each output beat is tagged with its source index.
- Keeps a saturating count of accepted beats for debug and observability.

Parameters:
N_SRC, 5, number of upstream sibling streams (2..16)
DATA_W, 16, payload width per stream
FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2)
CNT_W, 16, width of accepted-beat counter

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  N_SRC  per-source valid
in_ready  output  N_SRC  per-source ready (one-hot or zero)
in_data  input  N_SRC*DATA_W  packed payloads; source i at bits [i*DATA_W +: DATA_W]
out_valid  output  1  output beat available
out_ready  input  1  downstream accepts beat
out_data  output  DATA_W  head-of-FIFO payload
out_src  output  $clog2(N_SRC)  source index of head beat
fifo_level  output  $clog2(FIFO_DEPTH)+1  current occupancy
clear_cnt  input  1  synchronous clear of beat_count
beat_count  output  CNT_W  accepted input beats, saturating

Behaviour:
- Reset (async assert, sync release):
  - rr_ptr=0, FIFO empty, fifo_level=0.
  - out_valid=0, out_data=0, out_src=0, beat_count=0, in_ready all 0.
  - Contents in flight at reset are discarded.
- Space:
  - space = (fifo_level < FIFO_DEPTH), using the registered level.
  - A pop in the same cycle does NOT create space for a push.
- Arbitration (combinational, each cycle):
  - grant = first index i, searching rr_ptr, rr_ptr+1, ... modulo N_SRC, with in_valid[i]=1.
  - in_ready[i] = space && (i == grant) && in_valid[i]; at most one bit set.
  - in_ready may depend on in_valid. Upstream must not make in_valid depend on in_ready.
- Push:
  - Occurs when in_valid[g] && in_ready[g].
  - Writes {g, in_data[g]} at the tail.
  - On the next edge, rr_ptr = (g+1) mod N_SRC, with explicit wrap for non-power-of-2 N_SRC.
  - With no push, rr_ptr holds.
- Pop:
  - out_valid = (fifo_level != 0).
  - out_data and out_src are driven from the head entry with no extra register stage.
  - Pop occurs when out_valid && out_ready.
- Latency: a beat accepted at edge t is visible at the output after edge t (earliest pop at cycle t+1). Minimum latency is 1 cycle; there is no combinational input-to-output path.
- Occupancy: push-only: level+1; pop-only: level-1; push and pop together: level unchanged, pointers both advance.
- Pointers: wrap modulo FIFO_DEPTH, with one extra bit used for the full/empty distinction.
- Ordering: output order equals acceptance order, across and within sources.
- Stability: while out_valid=1 and out_ready=0, out_data and out_src hold stable.
- beat_count:
  - Increments by 1 per push; saturates at all-ones.
  - clear_cnt has priority: if clear_cnt and a push occur together, beat_count becomes 0.
- Fairness: with all sources continuously valid and no backpressure, each source is granted once every N_SRC pushes.
- Full: all in_ready=0; rr_ptr holds; upstream stalls without data loss.
- Empty: out_valid=0; out_data and out_src hold the last head contents. They are don't-care for checking, but must not be X after reset.

Decomposition:
- Package sibling_merge_pkg holds:
  - default constants: N_SRC_DEF=5, DATA_W_DEF=16, FIFO_DEPTH_DEF=4;
  - function src_idx_w(n) returning $clog2(n);
  - a packed struct typedef for the FIFO entry {src, data}.
- One sub-module: merge_sync_fifo.
  - Generic single-clock FIFO with push/pop/level and registered storage.
  - Same async active-high reset.
  - Instantiated once; the arbiter and counter stay in the top.

Test Plan:
1. Only source 2 valid, two beats 0x00A1, 0x00A2, out_ready=1 -> out beats 0x00A1 then 0x00A2 on consecutive cycles, first one cycle after acceptance, out_src=2, beat_count=2.
2. All five sources continuously valid, out_ready=1 -> grant/out_src sequence 0,1,2,3,4,0,1; fifo_level settles at 1; one beat out per cycle.
3. All sources valid, out_ready=0 -> exactly 4 beats accepted (src 0,1,2,3), then fifo_level=4 and in_ready=0, with rr_ptr=4 held. Raise out_ready -> drains in order 0,1,2,3, then src 4 is granted on the first cycle level<4.
4. Level=2 with a push and pop in the same cycle -> level stays 2, the popped beat is the oldest, and the new beat lands at the tail.
5. CNT_W=4, 20 pushes -> beat_count stops at 15. clear_cnt asserted together with a push -> beat_count=0 next cycle, then increments normally.
6. rst asserted asynchronously mid-cycle with level=3 -> immediately out_valid=0, fifo_level=0, in_ready=0. After release, the first grant goes to source 0 if it is valid.
